storage_compare_sequencer: RTL and testbench

Self-checking stimulus sequencer for the storage-element comparison datapath: a positive-level D latch, a negative-edge D flip-flop and a positive-edge D flip-flop, all sharing one clock and one D input. On `start` it drives a programmable bit pattern onto the shared D line for `len` cycles. Each cycle it samples the three Q outputs, checks each against its element-specific expected value, and counts mismatches per element. It sits between the bench or top-level control and the comparison datapath, and is the pass/fail front end for lab bring-up.

---
 rtl/storage_compare_sequencer_if.sv | 30 +++
 rtl/storage_compare_sequencer.sv | 161 ++++++++++++++++
 tb/tb_storage_compare_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/storage_compare_sequencer_if.sv
// Control/stimulus/result bundle between the bench or top-level control and
// the storage-element compare sequencer.
interface storage_compare_sequencer_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [1:0]       mode;
  logic [7:0]       seed;
  logic             d_out;
  logic             qa_in;
  logic             qb_in;
  logic             qc_in;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] err_a;
  logic [LEN_W-1:0] err_b;
  logic [LEN_W-1:0] err_c;
  logic             pass;

  modport master (
    output start, len, mode, seed, qa_in, qb_in, qc_in,
    input  d_out, busy, done, err_a, err_b, err_c, pass
  );

  modport slave (
    input  start, len, mode, seed, qa_in, qb_in, qc_in,
    output d_out, busy, done, err_a, err_b, err_c, pass
  );
endinterface

// File: rtl/storage_compare_sequencer.sv
// Drives a programmable bit pattern onto the shared D line of the latch /
// neg-edge FF / pos-edge FF datapath and counts per-element Q mismatches.
module storage_compare_sequencer #(
  parameter int unsigned LEN_W = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  storage_compare_sequencer_if.slave   bus
);

  localparam int unsigned PAT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_TAIL1 = 2'd2;
  localparam logic [1:0] ST_TAIL2 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       mode_q, mode_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             d_out_q, d_out_d;
  logic             d_prev_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] err_a_q, err_a_d;
  logic [LEN_W-1:0] err_b_q, err_b_d;
  logic [LEN_W-1:0] err_c_q, err_c_d;
  logic             pass_q, pass_d;

  logic [PAT_W-1:0] pat_next;
  logic [PAT_W-1:0] seed_load;
  logic             start_ok;
  logic             chk_ab;
  logic             chk_c;
  logic             mis_a;
  logic             mis_b;
  logic             mis_c;

  // pat_q[0] is always the bit currently on d_out; advance per mode
  always_comb begin
    pat_next = pat_q;
    case (mode_q)
      2'd0:    pat_next = {pat_q[PAT_W-1:1], ~pat_q[0]};
      2'd1:    pat_next = {pat_q[0] ^ pat_q[2] ^ pat_q[3] ^ pat_q[4], pat_q[PAT_W-1:1]};
      2'd2:    pat_next = {pat_q[0], pat_q[PAT_W-1:1]};
      default: pat_next = pat_q;
    endcase
  end

  // LFSR must never be loaded with the all-zero lockup state
  assign seed_load = (bus.mode == 2'd1 && bus.seed == 8'h00) ? 8'h01 : bus.seed;
  assign start_ok  = bus.start && (bus.len != '0);

  // X/Z on a Q input must count as a mismatch, hence case inequality
  assign mis_a = (bus.qa_in !== d_out_q);
  assign mis_b = (bus.qb_in !== d_out_q);
  assign mis_c = (bus.qc_in !== d_prev_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    d_out_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_a_d = err_a_q;
    err_b_d = err_b_q;
    err_c_d = err_c_q;
    chk_ab  = 1'b0;
    chk_c   = 1'b0;

    case (state_q)
      // TAIL2 is the done cycle; it accepts a start so runs can chain
      ST_IDLE, ST_TAIL2: begin
        state_d = ST_IDLE;
        if (start_ok) begin
          state_d = ST_RUN;
          len_d   = bus.len;
          mode_d  = bus.mode;
          pat_d   = seed_load;
          idx_d   = '0;
          d_out_d = seed_load[0];
          busy_d  = 1'b1;
          err_a_d = '0;
          err_b_d = '0;
          err_c_d = '0;
        end
      end
      ST_RUN: begin
        chk_ab = 1'b1;
        chk_c  = (idx_q != '0);
        busy_d = 1'b1;
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = ST_TAIL1;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          pat_d   = pat_next;
          d_out_d = pat_next[0];
        end
      end
      ST_TAIL1: begin
        chk_c   = 1'b1;
        state_d = ST_TAIL2;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // saturating mismatch counters
    if (chk_ab && mis_a && (err_a_q != {LEN_W{1'b1}})) err_a_d = err_a_q + LEN_W'(1);
    if (chk_ab && mis_b && (err_b_q != {LEN_W{1'b1}})) err_b_d = err_b_q + LEN_W'(1);
    if (chk_c  && mis_c && (err_c_q != {LEN_W{1'b1}})) err_c_d = err_c_q + LEN_W'(1);

    pass_d = (err_a_d == '0) && (err_b_d == '0) && (err_c_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      mode_q   <= 2'd0;
      pat_q    <= '0;
      d_out_q  <= 1'b0;
      d_prev_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_a_q  <= '0;
      err_b_q  <= '0;
      err_c_q  <= '0;
      pass_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      d_out_q  <= d_out_d;
      d_prev_q <= d_out_q;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_a_q  <= err_a_d;
      err_b_q  <= err_b_d;
      err_c_q  <= err_c_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err_a = err_a_q;
  assign bus.err_b = err_b_q;
  assign bus.err_c = err_c_q;
  assign bus.pass  = pass_q;

endmodule

// File: tb/tb_storage_compare_sequencer.sv
// Directed + randomized bench for storage_compare_sequencer with a
// pattern/expected-error reference model.
module tb_storage_compare_sequencer;

  localparam int unsigned LEN_W = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   tests    = 0;
  int   fails    = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  logic bits [0:255];

  always #5 clk = ~clk;

  storage_compare_sequencer_if #(.LEN_W(LEN_W)) bus ();

  storage_compare_sequencer #(.LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pattern bits straight from the mode rules
  task automatic gen_bits(input logic [1:0] m, input logic [7:0] s, input int n);
    logic [7:0] r;
    r = (s == 8'h00) ? 8'h01 : s;
    for (int j = 0; j < n; j++) begin
      case (m)
        2'd0: bits[j] = s[0] ^ j[0];
        2'd1: begin
          bits[j] = r[0];
          r = {r[0] ^ r[2] ^ r[3] ^ r[4], r[7:1]};
        end
        2'd2: bits[j] = s[j % 8];
        default: bits[j] = s[0];
      endcase
    end
  endtask

  // 0 = correct, 1 = stuck 0, 2 = inverted, 3 = random flips
  function automatic logic drive(input int fm, input logic good);
    case (fm)
      0: return good;
      1: return 1'b0;
      2: return ~good;
      default: return ($urandom_range(0, 3) == 0) ? ~good : good;
    endcase
  endfunction

  // Called #1 after a posedge; returns #1 after the done edge (done cycle)
  task automatic run(input string nm, input logic [1:0] m, input logic [7:0] s,
                     input int n, input int fa, input int fb, input int fc,
                     input bit poke);
    int   ea, eb, ec;
    logic va, vb, vc;
    ea = 0; eb = 0; ec = 0;
    gen_bits(m, s, n);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.seed  = s;
    bus.len   = LEN_W'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "/d_out0"}, 32'(bus.d_out), 32'(bits[0]));
    chk({nm, "/busy0"},  32'(bus.busy), 32'd1);
    chk({nm, "/done0"},  32'(bus.done), 32'd0);
    chk({nm, "/clr_a"},  32'(bus.err_a), 32'd0);
    chk({nm, "/clr_b"},  32'(bus.err_b), 32'd0);
    chk({nm, "/clr_c"},  32'(bus.err_c), 32'd0);
    for (int k = 1; k <= n + 1; k++) begin
      bus.start = poke && (k == 2 || k == 3);
      if (poke) begin
        bus.len  = LEN_W'(7);
        bus.mode = 2'd0;
      end
      if (k <= n) begin
        va = drive(fa, bits[k-1]);
        vb = drive(fb, bits[k-1]);
        if (va !== bits[k-1]) ea++;
        if (vb !== bits[k-1]) eb++;
      end else begin
        va = 1'($urandom);
        vb = 1'($urandom);
      end
      if (k >= 2) begin
        vc = drive(fc, bits[k-2]);
        if (vc !== bits[k-2]) ec++;
      end else begin
        vc = 1'($urandom);
      end
      bus.qa_in = va;
      bus.qb_in = vb;
      bus.qc_in = vc;
      @(posedge clk); #1;
      chk({nm, "/d_out"}, 32'(bus.d_out), (k < n) ? 32'(bits[k]) : 32'd0);
      chk({nm, "/busy"},  32'(bus.busy), (k <= n) ? 32'd1 : 32'd0);
      chk({nm, "/done"},  32'(bus.done), (k == n + 1) ? 32'd1 : 32'd0);
    end
    bus.start = 1'b0;
    if (ea > 255) ea = 255;
    if (eb > 255) eb = 255;
    if (ec > 255) ec = 255;
    chk({nm, "/err_a"}, 32'(bus.err_a), 32'(ea));
    chk({nm, "/err_b"}, 32'(bus.err_b), 32'(eb));
    chk({nm, "/err_c"}, 32'(bus.err_c), 32'(ec));
    chk({nm, "/pass"},  32'(bus.pass), (ea == 0 && eb == 0 && ec == 0) ? 32'd1 : 32'd0);
    exp_done++;
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      chk("idle/busy", 32'(bus.busy), 32'd0);
      chk("idle/done", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.len   = '0;
    bus.mode  = 2'd0;
    bus.seed  = 8'h00;
    bus.qa_in = 1'b0;
    bus.qb_in = 1'b0;
    bus.qc_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/d_out", 32'(bus.d_out), 32'd0);
    chk("rst/busy",  32'(bus.busy), 32'd0);
    chk("rst/done",  32'(bus.done), 32'd0);
    chk("rst/err_a", 32'(bus.err_a), 32'd0);
    chk("rst/err_b", 32'(bus.err_b), 32'd0);
    chk("rst/err_c", 32'(bus.err_c), 32'd0);
    chk("rst/pass",  32'(bus.pass), 32'd1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run("rot", 2'd2, 8'b1011_0010, 8, 0, 0, 0, 1'b0);
    idle(2);

    run("alt_qc0", 2'd0, 8'h00, 5, 0, 0, 1, 1'b0);
    idle(2);
    chk("hold/err_c", 32'(bus.err_c), 32'd2);
    chk("hold/pass",  32'(bus.pass), 32'd0);

    run("lfsr255", 2'd1, 8'h00, 255, 2, 0, 0, 1'b0);
    idle(1);

    run("poke", 2'd3, 8'h01, 4, 0, 0, 0, 1'b1);
    idle(1);
    bus.start = 1'b1;
    bus.len   = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("len0/busy", 32'(bus.busy), 32'd0);
    chk("len0/done", 32'(bus.done), 32'd0);
    idle(2);
    chk("len0/pass", 32'(bus.pass), 32'd1);

    // abort a run with counters likely nonzero
    bus.qa_in = 1'b1;
    bus.qb_in = 1'b1;
    bus.qc_in = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 2'd0;
    bus.seed  = 8'(($urandom));
    bus.len   = LEN_W'(10);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort/d_out", 32'(bus.d_out), 32'd0);
    chk("abort/busy",  32'(bus.busy), 32'd0);
    chk("abort/done",  32'(bus.done), 32'd0);
    chk("abort/err_a", 32'(bus.err_a), 32'd0);
    chk("abort/err_b", 32'(bus.err_b), 32'd0);
    chk("abort/err_c", 32'(bus.err_c), 32'd0);
    chk("abort/pass",  32'(bus.pass), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort/nodone", 32'(bus.done), 32'd0);
    run("post_rst", 2'd0, 8'(($urandom)), 3, 0, 3, 3, 1'b0);
    idle(1);

    // chained runs: start held during the done cycle
    run("bb1", 2'd2, 8'(($urandom)), 6, 3, 3, 3, 1'b0);
    run("bb2", 2'd1, 8'(($urandom)), 9, 3, 3, 3, 1'b0);
    idle(1);

    for (int i = 0; i < 8; i++) begin
      run("rnd", 2'($urandom), 8'(($urandom)), $urandom_range(1, 40),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      idle($urandom_range(0, 1));
    end
    idle(1);

    chk("done_count", 32'(done_cnt), 32'(exp_done));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
